// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default operand width.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage : serial_sub_pkg

// File: rtl/Half_Subtractor.sv
// One-bit half subtractor: diff = a ^ b, borrow = ~a & b.
module Half_Subtractor (
    input  logic a_i,
    input  logic b_i,
    output logic diff_o,
    output logic borrow_o
);

    assign diff_o   = a_i ^ b_i;
    assign borrow_o = ~a_i & b_i;

endmodule : Half_Subtractor

// File: rtl/serial_sub_4_bit.sv
// Bit-serial subtractor: captures a/b on an input handshake, resolves one bit per cycle
// LSB first, then presents diff/borrow/overflow until the consumer takes the result.
module serial_sub_4_bit
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             overflow_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic               accept_c;
    logic               last_bit_c;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic               bin_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               hs0_diff, hs0_borrow;
    logic               d_c, hs1_borrow, bout_c;
    logic [WIDTH-1:0]   res_next_c;

    // Full-subtract cell: first stage forms a-b, second stage subtracts the incoming borrow.
    Half_Subtractor u_hs0 (
        .a_i      (a_q[0]),
        .b_i      (b_q[0]),
        .diff_o   (hs0_diff),
        .borrow_o (hs0_borrow)
    );

    Half_Subtractor u_hs1 (
        .a_i      (hs0_diff),
        .b_i      (bin_q),
        .diff_o   (d_c),
        .borrow_o (hs1_borrow)
    );

    assign bout_c     = hs0_borrow | hs1_borrow;
    assign res_next_c = WIDTH'({d_c, res_q} >> 1);

    // Ready is masked by reset so it stays low while rst_ni is held.
    assign in_ready_o  = (state_q == ST_IDLE) && rst_ni;
    assign out_valid_o = (state_q == ST_DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        last_bit_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    accept_c = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    last_bit_c = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand shifters, running borrow and bit counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            bin_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept_c) begin
            a_q   <= a_i;
            b_q   <= b_i;
            res_q <= '0;
            bin_q <= 1'b0;
            cnt_q <= '0;
        end else if (state_q == ST_SHIFT) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            res_q <= res_next_c;
            bin_q <= bout_c;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Result registers load only on DONE entry; at that point a_q[0]/b_q[0] are the operand MSBs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            diff_o     <= '0;
            borrow_o   <= 1'b0;
            overflow_o <= 1'b0;
        end else if (last_bit_c) begin
            diff_o     <= res_next_c;
            borrow_o   <= bout_c;
            overflow_o <= (a_q[0] ^ b_q[0]) & (d_c ^ a_q[0]);
        end
    end

endmodule : serial_sub_4_bit

// File: tb/tb_serial_sub_4_bit.sv
// Self-checking bench for serial_sub_4_bit against an arithmetic reference model.
module tb_serial_sub_4_bit;

    localparam int W = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] diff_o;
    logic         borrow_o;
    logic         overflow_o;

    int n_cmp = 0;
    int n_err = 0;

    serial_sub_4_bit #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .diff_o      (diff_o),
        .borrow_o    (borrow_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int ua, ub, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        sr = sa - sb;
        d  = W'((ua - ub + 16) % 16);
        bo = (ua < ub);
        ov = (sr < -8) || (sr > 7);
    endtask

    // One full operation: accept, wait for result, hold back-pressure, release.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit poke);
        logic [W-1:0] ed;
        logic eb, eo;
        int lat;
        model(a, b, ed, eb, eo);
        @(negedge clk_i);
        n_cmp++;
        if (in_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL %s in_ready before accept: got %b want 1", tag, in_ready_o);
        end
        a_i = a; b_i = b; in_valid_i = 1'b1; out_ready_i = 1'b0;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        a_i = ~a; b_i = W'($urandom_range(0, 15));
        lat = 0;
        while (out_valid_o !== 1'b1 && lat < 40) begin
            if (poke) begin
                in_valid_i = 1'b1; a_i = W'($urandom_range(0, 15)); b_i = W'($urandom_range(0, 15));
                n_cmp++;
                if (in_ready_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s in_ready during shift: got %b want 0", tag, in_ready_o);
                end
            end
            @(posedge clk_i); #1;
            lat++;
        end
        n_cmp++;
        if (lat !== W) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, W);
        end
        n_cmp++;
        if ({diff_o, borrow_o, overflow_o} !== {ed, eb, eo}) begin
            n_err++;
            $display("FAIL %s result: got diff=%h b=%b o=%b want diff=%h b=%b o=%b",
                     tag, diff_o, borrow_o, overflow_o, ed, eb, eo);
        end
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid_i = ~in_valid_i; a_i = W'($urandom_range(0, 15)); b_i = W'($urandom_range(0, 15));
            end
            @(posedge clk_i); #1;
            n_cmp++;
            if ({out_valid_o, in_ready_o, diff_o, borrow_o, overflow_o} !== {1'b1, 1'b0, ed, eb, eo}) begin
                n_err++;
                $display("FAIL %s hold %0d: got v=%b r=%b diff=%h want v=1 r=0 diff=%h",
                         tag, i, out_valid_o, in_ready_o, diff_o, ed);
            end
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        n_cmp++;
        if ({out_valid_o, in_ready_o} !== 2'b01) begin
            n_err++;
            $display("FAIL %s release: got v=%b r=%b want v=0 r=1", tag, out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++;
        if ({in_ready_o, out_valid_o, diff_o, borrow_o, overflow_o} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got r=%b v=%b diff=%h b=%b o=%b want all 0",
                     in_ready_o, out_valid_o, diff_o, borrow_o, overflow_o);
        end
        // First handshake on the first edge after release.
        @(negedge clk_i);
        rst_ni = 1'b1; a_i = 4'h6; b_i = 4'h2; in_valid_i = 1'b1;
        #1;
        n_cmp++;
        if (in_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready_o);
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (W) @(posedge clk_i);
        #1;
        n_cmp++;
        if ({out_valid_o, diff_o} !== {1'b1, 4'h4}) begin
            n_err++;
            $display("FAIL reset_first_op: got v=%b diff=%h want v=1 diff=4", out_valid_o, diff_o);
        end
        @(negedge clk_i); out_ready_i = 1'b1;
        @(posedge clk_i); #1; out_ready_i = 1'b0;
    endtask

    task automatic test_directed();
        run_op("a9_b3", 4'h9, 4'h3, 0, 1'b0);
        run_op("a3_b9", 4'h3, 4'h9, 0, 1'b0);
        run_op("a7_bF", 4'h7, 4'hF, 0, 1'b0);
        run_op("a8_b1", 4'h8, 4'h1, 0, 1'b0);
        run_op("a0_b0", 4'h0, 4'h0, 0, 1'b0);
        run_op("aF_b0", 4'hF, 4'h0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op("bp_a9_b3", 4'h9, 4'h3, 5, 1'b1);
        run_op("bp_a2_bD", 4'h2, 4'hD, 5, 1'b1);
    endtask

    task automatic test_reset_abort();
        @(negedge clk_i);
        a_i = 4'h9; b_i = 4'h3; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(posedge clk_i); #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready_o, out_valid_o, diff_o, borrow_o, overflow_o} !== '0) begin
            n_err++;
            $display("FAIL abort_outputs: got r=%b v=%b diff=%h b=%b o=%b want all 0",
                     in_ready_o, out_valid_o, diff_o, borrow_o, overflow_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        n_cmp++;
        if (in_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL abort_ready: got %b want 1", in_ready_o);
        end
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk_i); #1;
            n_cmp++;
            if ({out_valid_o, diff_o} !== '0) begin
                n_err++;
                $display("FAIL abort_no_result %0d: got v=%b diff=%h want 0", i, out_valid_o, diff_o);
            end
        end
        run_op("post_abort_a5_b5", 4'h5, 4'h5, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            run_op("rand", W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    // Ready held on both sides: one op every W+2 cycles.
    task automatic test_back_to_back();
        logic [W-1:0] a, b, ed;
        logic eb, eo;
        out_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(0, 15));
            model(a, b, ed, eb, eo);
            @(negedge clk_i);
            a_i = a; b_i = b; in_valid_i = 1'b1;
            n_cmp++;
            if (in_ready_o !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready %0d: got %b want 1", k, in_ready_o);
            end
            @(posedge clk_i); #1;
            a_i = ~a;
            repeat (W) @(posedge clk_i);
            #1;
            n_cmp++;
            if ({out_valid_o, diff_o, borrow_o, overflow_o} !== {1'b1, ed, eb, eo}) begin
                n_err++;
                $display("FAIL b2b_result %0d: got v=%b diff=%h b=%b o=%b want v=1 diff=%h b=%b o=%b",
                         k, out_valid_o, diff_o, borrow_o, overflow_o, ed, eb, eo);
            end
            @(posedge clk_i); #1;
            n_cmp++;
            if ({out_valid_o, in_ready_o} !== 2'b01) begin
                n_err++;
                $display("FAIL b2b_release %0d: got v=%b r=%b want v=0 r=1", k, out_valid_o, in_ready_o);
            end
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_sub_4_bit
